// File: rtl/mips_pkg.sv
// Shared definitions for the MEM stage: access FSM states, error bit
// positions, default access timeout and the pipeline register layouts.
package mips_pkg;

  // Data-memory access controller states. DONE only matters if EX/MEM were
  // ever held by a freeze outside this stage; otherwise it falls back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Positions inside the sticky err_o vector.
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_TIMEOUT  = 1;

  // Default number of cycles a request may wait for ack before it is abandoned.
  localparam int TIMEOUT_DEFAULT = 16;

  // Width of the wait counter; large enough for TIMEOUT up to 255.
  localparam int CNT_W = 8;

  // EX/MEM pipeline register contents.
  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] alu;
    logic [31:0] rt_data;
    logic [4:0]  dest;
  } exmem_t;

  // MEM/WB pipeline register contents.
  typedef struct packed {
    logic        reg_write;
    logic [4:0]  dest;
    logic [31:0] data;
  } memwb_t;

  // Word accesses must have the two low address bits clear.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Data-memory handshake controller: issues the request, counts waited
// cycles, raises stall while the access is pending and aborts a request
// that has waited TIMEOUT-1 cycles without an ack.
module mem_access_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic access_i,
  input  logic ack_i,
  output logic req_o,
  output logic stall_o,
  output logic abort_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_s;
  logic             req_s;

  // The request drops in the abort cycle so a late ack can never complete it.
  assign abort_s = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);
  assign req_s   = access_i && (state_q != ST_DONE) && !abort_s;

  assign req_o   = req_s;
  assign stall_o = req_s && !ack_i;
  assign abort_o = abort_s;

  // Next-state and wait-count logic. The counter is zero whenever the FSM is
  // idle and already counts the first un-acked request cycle on entry to WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s && !ack_i) begin
          state_d = ST_WAIT;
          cnt_d   = 8'd1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      end
      ST_WAIT: begin
        if (ack_i || abort_s) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers around a single-port data
// memory with a request/ack handshake, misalignment and timeout detection,
// and sticky error reporting.
module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALU_result_i,
  input  logic [31:0] rt_data_i,
  input  logic [4:0]  dest_reg_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        EXMEM_RegWrite_o,
  output logic [4:0]  EXMEM_dest_reg_o,
  output logic [31:0] EXMEM_ALU_o,
  output logic        MEMWB_RegWrite_o,
  output logic [4:0]  MEMWB_dest_reg_o,
  output logic [31:0] MEMWB_WriteData_o,
  output logic [1:0]  err_o
);

  exmem_t     exmem_q, exmem_d;
  memwb_t     memwb_q, memwb_d;
  logic [1:0] err_q, err_d;

  logic memop_s;
  logic misaligned_s;
  logic access_s;
  logic req_s;
  logic stall_s;
  logic abort_s;

  // A read+write combination is handled as a write.
  assign memop_s      = exmem_q.mem_read | exmem_q.mem_write;
  assign misaligned_s = memop_s & is_misaligned(exmem_q.alu);
  assign access_s     = memop_s & ~misaligned_s;

  mem_access_ctrl #(
    .TIMEOUT (TIMEOUT)
  ) u_ctrl (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .access_i (access_s),
    .ack_i    (dmem_ack_i),
    .req_o    (req_s),
    .stall_o  (stall_s),
    .abort_o  (abort_s)
  );

  assign dmem_req_o   = req_s;
  assign dmem_we_o    = exmem_q.mem_write;
  assign dmem_addr_o  = exmem_q.alu;
  assign dmem_wdata_o = exmem_q.rt_data;
  assign stall_o      = stall_s;

  assign EXMEM_RegWrite_o = exmem_q.reg_write;
  assign EXMEM_dest_reg_o = exmem_q.dest;
  assign EXMEM_ALU_o      = exmem_q.alu;

  assign MEMWB_RegWrite_o  = memwb_q.reg_write;
  assign MEMWB_dest_reg_o  = memwb_q.dest;
  assign MEMWB_WriteData_o = memwb_q.data;
  assign err_o             = err_q;

  // EX/MEM captures the EX outputs unless the stage is stalled.
  always_comb begin
    exmem_d = exmem_q;
    if (stall_s) begin
      exmem_d = exmem_q;
    end else begin
      exmem_d.reg_write  = RegWrite_i;
      exmem_d.mem_to_reg = MemtoReg_i;
      exmem_d.mem_read   = MemRead_i;
      exmem_d.mem_write  = MemWrite_i;
      exmem_d.alu        = ALU_result_i;
      exmem_d.rt_data    = rt_data_i;
      exmem_d.dest       = dest_reg_i;
    end
  end

  // MEM/WB retires the EX/MEM instruction on non-stalled edges. Failed
  // accesses and stores never write back; a completed load takes the ack data.
  always_comb begin
    memwb_d = memwb_q;
    if (stall_s) begin
      memwb_d = memwb_q;
    end else begin
      memwb_d.reg_write = exmem_q.reg_write & ~misaligned_s & ~abort_s & ~exmem_q.mem_write;
      memwb_d.dest      = exmem_q.dest;
      if (exmem_q.mem_to_reg && !exmem_q.mem_write) begin
        memwb_d.data = dmem_rdata_i;
      end else begin
        memwb_d.data = exmem_q.alu;
      end
    end
  end

  // Sticky error flags accumulate until reset.
  always_comb begin
    err_d               = err_q;
    err_d[ERR_MISALIGN] = err_q[ERR_MISALIGN] | misaligned_s;
    err_d[ERR_TIMEOUT]  = err_q[ERR_TIMEOUT] | abort_s;
  end

  // Pipeline and error registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exmem_q <= '0;
      memwb_q <= '0;
      err_q   <= 2'b00;
    end else begin
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues instructions and pushes
// the expected retirement, a memory responder acks with per-access latency,
// and a monitor compares every MEM/WB retirement and memory-port cycle.
module tb_mem_stage;

  localparam int TMO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [31:0] ALU_result_i, rt_data_i;
  logic [4:0]  dest_reg_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic        EXMEM_RegWrite_o;
  logic [4:0]  EXMEM_dest_reg_o;
  logic [31:0] EXMEM_ALU_o;
  logic        MEMWB_RegWrite_o;
  logic [4:0]  MEMWB_dest_reg_o;
  logic [31:0] MEMWB_WriteData_o;
  logic [1:0]  err_o;

  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .ALU_result_i(ALU_result_i), .rt_data_i(rt_data_i), .dest_reg_i(dest_reg_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
    .EXMEM_RegWrite_o(EXMEM_RegWrite_o), .EXMEM_dest_reg_o(EXMEM_dest_reg_o), .EXMEM_ALU_o(EXMEM_ALU_o),
    .MEMWB_RegWrite_o(MEMWB_RegWrite_o), .MEMWB_dest_reg_o(MEMWB_dest_reg_o), .MEMWB_WriteData_o(MEMWB_WriteData_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        raw_rw;
    logic        rw;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        data_chk;
    int          stalls;
    int          reqc;
    logic        mis;
    logic        abt;
    logic        we;
    logic [31:0] alu;
    logic [31:0] rt;
  } exp_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
  } resp_t;

  exp_t       sb[$];
  resp_t      rq[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  bit         resp_en = 1'b0;
  logic [1:0] err_model = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h expected %h", name, act, exp);
    end
  endtask

  // Drive one instruction into EX, record its expected retirement, and hold
  // it until the stage accepts it.
  task automatic issue(input logic rw, input logic mtr, input logic mr, input logic mw,
                       input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] dest,
                       input int lat, input logic [31:0] rdata);
    exp_t  e;
    resp_t r;
    logic  memop;
    logic  access;
    int    guard;
    memop      = mr || mw;
    e.mis      = memop && (alu[1:0] != 2'b00);
    access     = memop && !e.mis;
    e.abt      = access && (lat >= TMO - 1);
    e.stalls   = access ? (e.abt ? TMO - 1 : lat) : 0;
    e.reqc     = access ? (e.abt ? TMO - 1 : lat + 1) : 0;
    e.raw_rw   = rw;
    e.rw       = rw && !e.mis && !e.abt && !mw;
    e.dest     = dest;
    e.data     = (mtr && !mw) ? rdata : alu;
    e.data_chk = e.rw || !mtr;
    e.we       = mw;
    e.alu      = alu;
    e.rt       = rt;
    if (access) begin
      r.lat   = lat;
      r.rdata = rdata;
      rq.push_back(r);
    end
    sb.push_back(e);
    RegWrite_i = rw; MemtoReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
    ALU_result_i = alu; rt_data_i = rt; dest_reg_i = dest;
    guard = 0;
    @(negedge clk_i);
    while (stall_o && guard < 64) begin
      guard++;
      @(negedge clk_i);
    end
    if (stall_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: stall_o still 1 after 64 cycles, expected 0");
    end
    @(posedge clk_i);
    #1;
  endtask

  // Memory responder: acks each request after its scripted latency and
  // throws spurious acks while no request is pending.
  initial begin
    int    cnt;
    bit    busy;
    logic  last_ack;
    resp_t cur;
    busy = 1'b0; cnt = 0; last_ack = 1'b0;
    cur.lat = 0; cur.rdata = 32'd0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!resp_en) begin
        busy = 1'b0;
        last_ack = 1'b0;
      end else begin
        if (busy) begin
          if (last_ack || !dmem_req_o) busy = 1'b0;
          else cnt++;
        end
        if (dmem_req_o && !busy) begin
          if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: addr %h with no access expected", dmem_addr_o);
            cur.lat = 0;
            cur.rdata = 32'd0;
          end else begin
            cur = rq.pop_front();
          end
          busy = 1'b1;
          cnt = 0;
        end
        if (busy && cnt == cur.lat) begin
          dmem_ack_i = 1'b1;
          dmem_rdata_i = cur.rdata;
        end else begin
          dmem_ack_i = busy ? 1'b0 : 1'($urandom_range(0, 1));
          dmem_rdata_i = $urandom;
        end
        last_ack = busy && dmem_ack_i;
      end
    end
  end

  // Monitor: tracks the instruction in EX/MEM, checks the memory port each
  // cycle, and compares MEM/WB after every non-stalled edge.
  initial begin
    exp_t slot, ret, last;
    bit   slot_v, retiring;
    int   st_cnt, rq_cnt, ret_st, ret_rq;
    slot_v = 1'b0; st_cnt = 0; rq_cnt = 0;
    last.rw = 1'b0; last.dest = 5'd0; last.data = 32'd0; last.data_chk = 1'b1;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        if (slot_v) begin
          if (dmem_req_o) begin
            rq_cnt++;
            chk("dmem_addr", dmem_addr_o, slot.alu);
            chk("dmem_we", 32'(dmem_we_o), 32'(slot.we));
            chk("dmem_wdata", dmem_wdata_o, slot.rt);
          end
          if (stall_o) begin
            st_cnt++;
            chk("hold_memwb_rw", 32'(MEMWB_RegWrite_o), 32'(last.rw));
            chk("hold_memwb_dest", 32'(MEMWB_dest_reg_o), 32'(last.dest));
            if (last.data_chk) chk("hold_memwb_data", MEMWB_WriteData_o, last.data);
          end
        end else begin
          chk("idle_req", 32'(dmem_req_o), 32'd0);
        end
        if (!stall_o) begin
          retiring = slot_v;
          ret = slot;
          ret_st = st_cnt;
          ret_rq = rq_cnt;
          st_cnt = 0;
          rq_cnt = 0;
          if (sb.size() > 0) begin
            slot = sb.pop_front();
            slot_v = 1'b1;
          end else begin
            slot_v = 1'b0;
          end
          @(posedge clk_i);
          #1;
          if (retiring) begin
            err_model = err_model | {ret.abt, ret.mis};
            chk("memwb_rw", 32'(MEMWB_RegWrite_o), 32'(ret.rw));
            chk("memwb_dest", 32'(MEMWB_dest_reg_o), 32'(ret.dest));
            if (ret.data_chk) chk("memwb_data", MEMWB_WriteData_o, ret.data);
            chk("stall_cycles", 32'(ret_st), 32'(ret.stalls));
            chk("req_cycles", 32'(ret_rq), 32'(ret.reqc));
            chk("err", 32'(err_o), 32'(err_model));
            last = ret;
          end
          if (slot_v) begin
            chk("exmem_alu", EXMEM_ALU_o, slot.alu);
            chk("exmem_dest", 32'(EXMEM_dest_reg_o), 32'(slot.dest));
            chk("exmem_rw", 32'(EXMEM_RegWrite_o), 32'(slot.raw_rw));
          end
        end
      end
    end
  end

  // Absolute time bound so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
    $fatal(1);
  end

  // Main sequence: reset, directed scenarios, random traffic, reset-in-WAIT.
  initial begin
    logic        kind_rw, mtr, mr, mw;
    logic [31:0] alu;
    int          kind, lat;
    rst_i = 1'b1;
    RegWrite_i = 1'b0; MemtoReg_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    ALU_result_i = 32'd0; rt_data_i = 32'd0; dest_reg_i = 5'd0;
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_exmem_alu", EXMEM_ALU_o, 32'd0);
    chk("rst_memwb_rw", 32'(MEMWB_RegWrite_o), 32'd0);
    chk("rst_memwb_data", MEMWB_WriteData_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    mon_en = 1'b1;
    resp_en = 1'b1;

    // Directed scenarios
    issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd3, 0, 32'hDEADBEEF);
    issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 32'h12345678, 5'd4, 3, 32'h0BADF00D);
    issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd5, 0, 32'h11111111);
    issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h108, 32'h0, 5'd6, 255, 32'h22222222);
    issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h10C, 32'h0, 5'd7, 2, 32'hCAFEF00D);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h7, 32'h0, 5'd8, 0, 32'h0);
    issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h110, 32'h0, 5'd9, TMO - 2, 32'h33333333);
    issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h114, 32'h0, 5'd10, TMO - 1, 32'h44444444);
    issue(1'b1, 1'b1, 1'b1, 1'b1, 32'h118, 32'hA5A5A5A5, 5'd11, 1, 32'h55555555);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 3);
      kind_rw = 1'($urandom_range(0, 1));
      mtr = 1'b0; mr = 1'b0; mw = 1'b0;
      case (kind)
        0: begin end
        1: begin kind_rw = 1'b1; mtr = 1'b1; mr = 1'b1; end
        2: begin mw = 1'b1; mtr = 1'($urandom_range(0, 1)); end
        default: begin mr = 1'b1; mw = 1'b1; mtr = 1'($urandom_range(0, 1)); end
      endcase
      alu = $urandom;
      if ((mr || mw) && $urandom_range(0, 5) != 0) alu[1:0] = 2'b00;
      lat = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 1, TMO + 4) : $urandom_range(0, 4);
      issue(kind_rw, mtr, mr, mw, alu, $urandom, 5'($urandom_range(0, 31)), lat, $urandom);
    end

    // Bubbles to retire the last instruction
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 0, 32'd0);
    end
    repeat (2) @(posedge clk_i);
    #3;
    mon_en = 1'b0;
    resp_en = 1'b0;
    dmem_ack_i = 1'b0;

    // Reset during the second WAIT cycle, then a late ack
    @(posedge clk_i);
    #1;
    RegWrite_i = 1'b1; MemtoReg_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0;
    ALU_result_i = 32'h200; rt_data_i = 32'd0; dest_reg_i = 5'd9;
    @(posedge clk_i);
    #1;
    chk("rw_first_stall", 32'(stall_o), 32'd1);
    @(posedge clk_i);
    #1;
    chk("rw_wait1_stall", 32'(stall_o), 32'd1);
    @(posedge clk_i);
    #1;
    chk("rw_wait2_stall", 32'(stall_o), 32'd1);
    rst_i = 1'b1;
    RegWrite_i = 1'b0; MemtoReg_i = 1'b0; MemRead_i = 1'b0;
    ALU_result_i = 32'd0; dest_reg_i = 5'd0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'hBADC0FFE;
    chk("rw_req", 32'(dmem_req_o), 32'd0);
    chk("rw_stall", 32'(stall_o), 32'd0);
    chk("rw_we", 32'(dmem_we_o), 32'd0);
    chk("rw_addr", dmem_addr_o, 32'd0);
    chk("rw_wdata", dmem_wdata_o, 32'd0);
    chk("rw_exmem_rw", 32'(EXMEM_RegWrite_o), 32'd0);
    chk("rw_exmem_dest", 32'(EXMEM_dest_reg_o), 32'd0);
    chk("rw_exmem_alu", EXMEM_ALU_o, 32'd0);
    chk("rw_memwb_rw", 32'(MEMWB_RegWrite_o), 32'd0);
    chk("rw_memwb_dest", 32'(MEMWB_dest_reg_o), 32'd0);
    chk("rw_memwb_data", MEMWB_WriteData_o, 32'd0);
    chk("rw_err", 32'(err_o), 32'd0);
    @(posedge clk_i);
    #1;
    dmem_ack_i = 1'b0;
    chk("rw_late_memwb_rw", 32'(MEMWB_RegWrite_o), 32'd0);
    chk("rw_late_memwb_data", MEMWB_WriteData_o, 32'd0);
    chk("rw_late_err", 32'(err_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
